aes_io_ctrl: RTL and testbench

AES_IO_CTRL -- requirements
Module: aes_io_ctrl

---
 rtl/aes_io_ctrl_if.sv | 29 ++
 rtl/aes_io_ctrl.sv | 164 ++++++++++++++++
 tb/tb_aes_io_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_io_ctrl_if.sv
// Host stream and cipher-core signal bundle for aes_io_ctrl.
// The slave modport is the controller's view; the master modport is the environment's view.
interface aes_io_ctrl_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              key_reuse;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              core_ld;
  logic [BLK_W-1:0]  core_key;
  logic [BLK_W-1:0]  core_text_in;
  logic              core_done;
  logic [BLK_W-1:0]  core_text_out;

  modport slave (
    input  in_valid, in_data, key_reuse, out_ready, core_done, core_text_out,
    output in_ready, out_valid, out_data, core_ld, core_key, core_text_in
  );

  modport master (
    output in_valid, in_data, key_reuse, out_ready, core_done, core_text_out,
    input  in_ready, out_valid, out_data, core_ld, core_key, core_text_in
  );
endinterface

// File: rtl/aes_io_ctrl.sv
// Host-side I/O controller for a 128-bit block cipher core: gathers key/text words,
// launches the core under a watchdog, then streams the 128-bit result out MSW first.
module aes_io_ctrl #(
  parameter int unsigned WDOG = 63
) (
  input  logic         clk,
  input  logic         rst,
  aes_io_ctrl_if.slave io,
  output logic         busy,
  output logic         err
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned NWORD  = BLK_W / WORD_W;
  localparam int unsigned WC_W   = 3;
  localparam int unsigned WD_W   = 6;
  localparam int unsigned OC_W   = 2;

  localparam logic [WC_W-1:0] TEXT_BASE = WC_W'(NWORD);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(2 * NWORD - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WDOG - 1);
  localparam logic [OC_W-1:0] OUT_LAST  = OC_W'(NWORD - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_q, state_n;

  logic [WC_W-1:0]   wcnt_q;
  logic [WD_W-1:0]   wdog_q;
  logic [OC_W-1:0]   ocnt_q;
  logic [BLK_W-1:0]  key_q;
  logic [BLK_W-1:0]  text_q;
  logic [BLK_W-1:0]  result_q;
  logic [WORD_W-1:0] out_data_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              core_ld_q;
  logic              busy_q;
  logic              err_q;

  logic              in_fire;
  logic              out_fire;
  logic              first_word;
  logic              done_hit;
  logic              wdog_expire;
  logic [WC_W-1:0]   widx;

  // Select one 32-bit word of a block, word 0 being the most significant.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                 input logic [OC_W-1:0]  idx);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(NWORD); i++) begin
      if (idx == OC_W'(i)) w = blk[BLK_W-1-WORD_W*i -: WORD_W];
    end
    return w;
  endfunction

  assign in_fire    = io.in_valid & in_ready_q;
  assign out_fire   = io.out_ready & out_valid_q;
  assign first_word = (wcnt_q == '0);
  // A key-reuse block starts directly at the first text slot.
  assign widx       = (first_word && io.key_reuse) ? TEXT_BASE : wcnt_q;

  // Completion beats the watchdog when both land in the same cycle.
  assign done_hit    = (state_q == S_BUSY) && io.core_done;
  assign wdog_expire = (state_q == S_BUSY) && !io.core_done && (wdog_q == WD_LAST);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_LOAD:  if (in_fire && (widx == LAST_WORD)) state_n = S_START;
      S_START: state_n = S_BUSY;
      S_BUSY: begin
        if (done_hit)         state_n = S_OUT;
        else if (wdog_expire) state_n = S_LOAD;
      end
      S_OUT:   if (out_fire && (ocnt_q == OUT_LAST)) state_n = S_LOAD;
      default: state_n = S_LOAD;
    endcase
  end

  // State and control outputs; outputs are decoded from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      core_ld_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      in_ready_q  <= (state_n == S_LOAD);
      out_valid_q <= (state_n == S_OUT);
      core_ld_q   <= (state_n == S_START);
      busy_q      <= (state_n != S_LOAD);
      if (wdog_expire)               err_q <= 1'b1;
      else if (in_fire && first_word) err_q <= 1'b0;
    end
  end

  // Input word counter and key/text assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
      key_q  <= '0;
      text_q <= '0;
    end else begin
      if (wdog_expire) begin
        wcnt_q <= '0;
      end else if (in_fire) begin
        wcnt_q <= widx + WC_W'(1);
        for (int i = 0; i < int'(NWORD); i++) begin
          if (widx[OC_W-1:0] == OC_W'(i)) begin
            if (widx[WC_W-1]) text_q[BLK_W-1-WORD_W*i -: WORD_W] <= io.in_data;
            else              key_q[BLK_W-1-WORD_W*i -: WORD_W]  <= io.in_data;
          end
        end
      end
    end
  end

  // Watchdog: zeroed while in START so BUSY always begins at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (state_q == S_START) begin
      wdog_q <= '0;
    end else if (state_q == S_BUSY) begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end

  // Result capture and output word sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q   <= '0;
      out_data_q <= '0;
      ocnt_q     <= '0;
    end else if (done_hit) begin
      result_q   <= io.core_text_out;
      out_data_q <= io.core_text_out[BLK_W-1 -: WORD_W];
      ocnt_q     <= '0;
    end else if (out_fire) begin
      ocnt_q     <= ocnt_q + OC_W'(1);
      out_data_q <= word_sel(result_q, ocnt_q + OC_W'(1));
    end
  end

  assign io.in_ready     = in_ready_q;
  assign io.out_valid    = out_valid_q;
  assign io.out_data     = out_data_q;
  assign io.core_ld      = core_ld_q;
  assign io.core_key     = key_q;
  assign io.core_text_in = text_q;
  assign busy            = busy_q;
  assign err             = err_q;
endmodule

// File: tb/tb_aes_io_ctrl.sv
// Self-checking bench for aes_io_ctrl: an AES-128 reference model serves as the cipher core
// and as the scoreboard for table vectors, corner sequences and random blocks.
module tb_aes_io_ctrl;
  localparam int unsigned WDOG = 63;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, err;

  aes_io_ctrl_if io ();

  aes_io_ctrl #(.WDOG(WDOG)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic         auto_done = 1'b0;
  logic         manual_done = 1'b0;
  logic         core_en = 1'b0;
  logic [127:0] auto_out = '0;
  logic [127:0] man_out = '0;
  logic [127:0] core_res = '0;
  int           core_lat = 1;
  int           pend = 0;
  int           ld_cnt = 0;
  int           ov_cnt = 0;
  logic [127:0] ld_key = '0;
  logic [127:0] ld_pt = '0;
  logic [127:0] model_key = '0;

  assign io.core_done     = auto_done | manual_done;
  assign io.core_text_out = manual_done ? man_out : auto_out;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic         kr;
    int           lat;
    int           stall;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [4];

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3, rc;
    logic [31:0]  tmp;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) begin
      tmp  = w[i/4];
      s[i] = pt[127-8*i -: 8] ^ tmp[31-8*(i%4) -: 8];
    end
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int ro = 0; ro < 4; ro++)
        for (int c = 0; c < 4; c++) s[ro+4*c] = t[ro+4*((c+ro)%4)];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) begin
        tmp  = w[4*rd + i/4];
        s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] p, q;
      p = 8'(x);
      q = 8'h01;
      for (int k = 1; k < 8; k++) begin
        p = gmul(p, p);
        q = gmul(q, p);
      end
      sb[x] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end
  end

  // Cipher core stand-in: answers each load after core_lat cycles when enabled.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      auto_done = 1'b0;
      pend      = 0;
    end else begin
      auto_done = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          auto_done = 1'b1;
          auto_out  = core_res;
        end
      end
      if (io.core_ld && core_en) begin
        pend     = core_lat;
        core_res = aes_enc(io.core_key, io.core_text_in);
      end
    end
  end

  // Load-strobe and output-valid observation.
  always @(negedge clk) begin
    if (rst === 1'b1 && io.core_ld) begin
      ld_cnt = ld_cnt + 1;
      ld_key = io.core_key;
      ld_pt  = io.core_text_in;
    end
    if (io.out_valid) ov_cnt = ov_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    manual_done = 1'b0;
    #1;
    chk("rst_in_ready", 128'(io.in_ready), '0);
    chk("rst_out_valid", 128'(io.out_valid), '0);
    chk("rst_core_ld", 128'(io.core_ld), '0);
    chk("rst_busy", 128'(busy), '0);
    chk("rst_err", 128'(err), '0);
    chk("rst_out_data", 128'(io.out_data), '0);
    chk("rst_core_key", io.core_key, '0);
    chk("rst_core_text", io.core_text_in, '0);
    step();
    rst = 1'b1;
    model_key = '0;
    step();
    chk("post_rst_in_ready", 128'(io.in_ready), 128'(1));
  endtask

  task automatic send_word(input logic [31:0] w, input logic kr, input int gaps);
    int   cyc;
    logic hs;
    cyc = 0;
    hs  = 1'b0;
    if (gaps > 0) repeat ($urandom_range(0, gaps)) step();
    io.in_valid  = 1'b1;
    io.in_data   = w;
    io.key_reuse = kr;
    while (!hs && cyc < 200) begin
      hs = io.in_ready;
      step();
      cyc++;
    end
    io.in_valid  = 1'b0;
    io.key_reuse = 1'b0;
    io.in_data   = $urandom;
    if (!hs) chk("in_handshake", 128'(hs), 128'(1));
  endtask

  task automatic send_block(input logic [127:0] key, input logic [127:0] pt, input logic kr, input int gaps);
    if (!kr) begin
      for (int i = 0; i < 4; i++)
        send_word(key[127-32*i -: 32], (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), gaps);
      model_key = key;
    end
    for (int i = 0; i < 4; i++)
      send_word(pt[127-32*i -: 32], (kr && i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), gaps);
  endtask

  task automatic recv(input int stall, output logic [127:0] got);
    int          n, cyc;
    logic [31:0] held;
    logic        hold_v;
    n = 0; cyc = 0; hold_v = 1'b0; held = '0; got = '0;
    while (n < 4 && cyc < 400) begin
      case (stall)
        0:       io.out_ready = 1'b1;
        1:       io.out_ready = (cyc % 2 == 0);
        default: io.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (io.out_valid) begin
        chk("in_ready_during_out", 128'(io.in_ready), '0);
        if (hold_v) chk("out_data_hold", 128'(io.out_data), 128'(held));
        if (io.out_ready) begin
          got[127-32*n -: 32] = io.out_data;
          n++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          held   = io.out_data;
        end
      end
      step();
      cyc++;
    end
    io.out_ready = 1'b0;
    chk("out_word_count", 128'(n), 128'(4));
    chk("in_ready_after_out", 128'(io.in_ready), 128'(1));
    chk("out_valid_after_out", 128'(io.out_valid), '0);
  endtask

  task automatic run_block(input vec_t v, input int gaps, output logic [127:0] got);
    int ld0;
    ld0 = ld_cnt;
    core_lat = v.lat;
    send_block(v.key, v.pt, v.kr, gaps);
    chk("start_core_ld", 128'(io.core_ld), 128'(1));
    chk("start_in_ready", 128'(io.in_ready), '0);
    chk("start_busy", 128'(busy), 128'(1));
    recv(v.stall, got);
    chk("core_ld_once", 128'(ld_cnt - ld0), 128'(1));
    chk("core_key", ld_key, model_key);
    chk("core_text", ld_pt, v.pt);
    chk("err_after_block", 128'(err), '0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [127:0] got, x, ek;
    vec_t         v;
    int           n, ov0;

    io.in_valid = 1'b0; io.in_data = '0; io.key_reuse = 1'b0; io.out_ready = 1'b0;
    tbl[0] = '{FIPS_KEY, FIPS_PT, 1'b0, 3,    0, FIPS_CT};
    tbl[1] = '{FIPS_KEY, FIPS_PT, 1'b1, 7,    1, FIPS_CT};
    tbl[2] = '{B_KEY,    B_PT,    1'b0, WDOG, 2, B_CT};
    tbl[3] = '{'0,       '0,      1'b0, 1,    1, ZERO_CT};

    repeat (2) @(posedge clk);
    #1;
    apply_reset();
    core_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_block(tbl[i], 0, got);
      chk($sformatf("vec%0d_ct", i), got, tbl[i].exp);
    end

    // Core never answers: watchdog fires, no output, err sticky until next first word.
    core_en = 1'b0;
    ov0 = ov_cnt;
    send_block(B_KEY, B_PT, 1'b0, 0);
    step();
    n = 0;
    while (!err && n < 200) begin
      step();
      n++;
    end
    chk("wdog_cycles", 128'(n), 128'(WDOG));
    chk("wdog_in_ready", 128'(io.in_ready), 128'(1));
    chk("wdog_busy", 128'(busy), '0);
    repeat (3) step();
    chk("wdog_err_sticky", 128'(err), 128'(1));
    chk("wdog_no_output", 128'(ov_cnt - ov0), '0);
    send_word(B_PT[127:96], 1'b1, 0);
    chk("err_cleared", 128'(err), '0);
    apply_reset();

    // Done in LOAD ignored; done on the watchdog's last cycle is captured.
    man_out = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    chk("load_done_busy", 128'(busy), '0);
    chk("load_done_in_ready", 128'(io.in_ready), 128'(1));
    chk("load_done_out_valid", 128'(io.out_valid), '0);
    send_block(FIPS_KEY, FIPS_PT, 1'b0, 0);
    step();
    repeat (WDOG - 1) step();
    x = {$urandom, $urandom, $urandom, $urandom};
    man_out = x;
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    chk("late_done_out_valid", 128'(io.out_valid), 128'(1));
    chk("late_done_err", 128'(err), '0);
    chk("late_done_word0", 128'(io.out_data), 128'(x[127:96]));
    recv(0, got);
    chk("late_done_result", got, x);
    core_en = 1'b1;

    // Reset after five input words, then a clean full block.
    for (int i = 0; i < 4; i++) send_word(FIPS_KEY[127-32*i -: 32], 1'b0, 0);
    send_word(FIPS_PT[127:96], 1'b0, 0);
    apply_reset();
    v = tbl[0];
    run_block(v, 0, got);
    chk("post_reset_ct", got, FIPS_CT);

    // Reset while results are pending: nothing may come out afterwards.
    core_lat = 2;
    send_block(B_KEY, B_PT, 1'b0, 0);
    n = 0;
    while (!io.out_valid && n < 200) begin
      step();
      n++;
    end
    chk("reach_out", 128'(io.out_valid), 128'(1));
    apply_reset();
    ov0 = ov_cnt;
    repeat (5) step();
    chk("no_partial_out", 128'(ov_cnt - ov0), '0);

    // Randomized blocks against the reference model.
    for (int i = 0; i < 25; i++) begin
      v.kr    = ($urandom_range(0, 2) == 0);
      v.key   = {$urandom, $urandom, $urandom, $urandom};
      v.pt    = {$urandom, $urandom, $urandom, $urandom};
      v.lat   = $urandom_range(1, WDOG);
      v.stall = $urandom_range(0, 2);
      ek      = v.kr ? model_key : v.key;
      v.exp   = aes_enc(ek, v.pt);
      run_block(v, 1, got);
      chk($sformatf("rand%0d_ct", i), got, v.exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
